// File: rtl/bcd_sseg_scanner_if.sv
// Bundle between a BCD producer and the four-digit seven-segment scanner.
// The producer side (master) drives the digits and display controls; the
// scanner side (slave) drives the board anodes, cathodes and the error flag.
// Optional macro: SSEG_BRIGHTNESS_EN adds the 2-bit dim control.
interface bcd_sseg_scanner_if;

   logic [3:0][3:0] bcd_in;    // element 0 = rightmost digit
   logic            load;      // one-cycle capture strobe
   logic            lz_blank;  // blank leading zeros
   logic [3:0]      dp_sel;    // per-digit decimal point enable
`ifdef SSEG_BRIGHTNESS_EN
   logic [1:0]      dim;       // on-duty (dim+1)/4 inside each digit slot
`endif
   logic [3:0]      an;        // anode select, one-hot at the active level
   logic [6:0]      seg;       // {g,f,e,d,c,b,a}
   logic            dp;        // decimal point cathode
   logic            err;       // last loaded value had a nibble above 9

   modport master (
`ifdef SSEG_BRIGHTNESS_EN
      output dim,
`endif
      output bcd_in, load, lz_blank, dp_sel,
      input  an, seg, dp, err
   );

   modport slave (
`ifdef SSEG_BRIGHTNESS_EN
      input  dim,
`endif
      input  bcd_in, load, lz_blank, dp_sel,
      output an, seg, dp, err
   );

endinterface : bcd_sseg_scanner_if

// File: rtl/bcd_sseg_scanner.sv
// Four-digit time-multiplexed seven-segment driver.
// A load strobe copies the BCD result into a shadow register; a free-running
// refresh counter walks the digits 0,1,2,3 using its top two bits, and the
// anode/cathode drive is registered so every output changes on a clock edge.
// Leading zeros may be blanked and nibbles 10..15 are shown as a dash.
// REFRESH_BITS must be at least 4 (digit slot = 2^(REFRESH_BITS-2) clocks).
// Optional macro: SSEG_BRIGHTNESS_EN gates the anode inside each digit slot
// with the dim input, giving a duty of (dim+1)/4.
module bcd_sseg_scanner #(
   parameter int REFRESH_BITS = 18,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic               clk,
   input  logic               reset,
   bcd_sseg_scanner_if.slave  bus
);

   // Inactive drive level of every anode, cathode and the decimal point.
   localparam logic                    POL     = (ACTIVE_LOW != 0);
   localparam logic [3:0]              AN_OFF  = {4{POL}};
   localparam logic [6:0]              SEG_OFF = {7{POL}};
   localparam logic                    DP_OFF  = POL;
   localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

   // Segment pattern for a nibble in active-high form; 10..15 show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] value);
      logic [6:0] pattern;
      case (value)
         4'd0:    pattern = 7'h3F;
         4'd1:    pattern = 7'h06;
         4'd2:    pattern = 7'h5B;
         4'd3:    pattern = 7'h4F;
         4'd4:    pattern = 7'h66;
         4'd5:    pattern = 7'h6D;
         4'd6:    pattern = 7'h7D;
         4'd7:    pattern = 7'h07;
         4'd8:    pattern = 7'h7F;
         4'd9:    pattern = 7'h6F;
         default: pattern = 7'h40;
      endcase
      return pattern;
   endfunction

   // True when any of the four nibbles is not a legal BCD digit.
   function automatic logic has_bad_digit(input logic [3:0][3:0] digits);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bad = bad | (digits[i] > 4'd9);
      end
      return bad;
   endfunction

   logic [REFRESH_BITS-1:0] refresh_cnt;
   logic [3:0][3:0]         shadow;
   logic                    err_q;
   logic [1:0]              digit_idx;
   logic [3:0]              blank;
   logic                    zero_above;
   logic [3:0]              digit_val;
   logic [3:0]              an_hi;
   logic [6:0]              seg_hi;
   logic                    dp_hi;
   logic [3:0]              an_q;
   logic [6:0]              seg_q;
   logic                    dp_q;

   assign digit_idx = refresh_cnt[REFRESH_BITS-1 -: 2];

   // Free-running refresh counter; wraps from all-ones straight to zero.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every flop samples the values that
      // were present before the edge, independent of statement order.
      if (reset) begin
         refresh_cnt <= '0;
      end else begin
         refresh_cnt <= refresh_cnt + CNT_ONE;
      end
   end

   // Shadow copy of the loaded digits plus the invalid-digit flag.
   always_ff @(posedge clk) begin
      // NOTE: the shadow is only four nibbles, and it must read as 0000 after
      // reset, so it is cleared here rather than left uninitialised.
      if (reset) begin
         shadow <= '0;
         err_q  <= 1'b0;
      end else if (bus.load) begin
         shadow <= bus.bcd_in;
         err_q  <= has_bad_digit(bus.bcd_in);
      end
   end

   // Leading-zero mask: a digit blanks when it and every digit above are zero.
   always_comb begin
      // NOTE: every variable gets a value before any conditional logic so no
      // path can leave it unassigned and infer a latch.
      blank      = '0;
      zero_above = bus.lz_blank;
      for (int i = 3; i >= 1; i--) begin
         zero_above = zero_above & (shadow[i] == 4'd0);
         blank[i]   = zero_above;
      end
   end

   // Active-high drive for the digit currently being scanned.
   always_comb begin
      an_hi     = '0;
      seg_hi    = '0;
      dp_hi     = 1'b0;
      digit_val = shadow[digit_idx];
      an_hi     = 4'b0001 << digit_idx;
      seg_hi    = blank[digit_idx] ? 7'h00 : seg_decode(digit_val);
      dp_hi     = bus.dp_sel[digit_idx];
`ifdef SSEG_BRIGHTNESS_EN
      // Sub-phase within the slot; past the dim threshold the digit is dark.
      if (refresh_cnt[REFRESH_BITS-3 -: 2] > bus.dim) begin
         an_hi  = '0;
         seg_hi = '0;
         dp_hi  = 1'b0;
      end
`endif
   end

   // Registered board drive, converted to the configured polarity.
   always_ff @(posedge clk) begin
      if (reset) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         dp_q  <= DP_OFF;
      end else begin
         an_q  <= an_hi ^ AN_OFF;
         seg_q <= seg_hi ^ SEG_OFF;
         dp_q  <= dp_hi ^ DP_OFF;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.err = err_q;

endmodule : bcd_sseg_scanner
